// File: rtl/pacman_beam_gen_pkg.sv
// pacman_beam_gen_pkg: default VGA 640x480 timing, Pacman visible-area size and
// the sync/window bundle carried through the colour-alignment delay line.
package pacman_beam_gen_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int PACMAN_VIS_W  = 224;
  localparam int PACMAN_VIS_H  = 288;
  function automatic int win_off(input int vis, input int game, input int scale);
    return (vis - game * scale) / 2;
  endfunction
  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_H_OFF   = win_off(VGA_H_VISIBLE, PACMAN_VIS_W, 1);
  localparam int VGA_V_OFF   = win_off(VGA_V_VISIBLE, PACMAN_VIS_H, 1);
  typedef struct packed {
    logic hs;
    logic vs;
    logic win;
  } sync_t;
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: N-stage shift register for {hs, vs, win}, cleared to inactive
// by an asynchronous active-low reset.
module vga_sync_delay
  import pacman_beam_gen_pkg::*;
#(
  parameter int N = 2
)(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  sync_t d_i,
  output sync_t q_o
);
  sync_t sr_q [N];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[N-1];
endmodule

// File: rtl/pacman_beam_gen.sv
// pacman_beam_gen: VGA raster counters, 224x288 game-pixel beam interface and
// window-blanked colour output with sync delay-matched to the game core.
module pacman_beam_gen
  import pacman_beam_gen_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int GAME_W     = PACMAN_VIS_W,
  parameter int GAME_H     = PACMAN_VIS_H,
  parameter int SCALE      = 1,
  parameter int PIPE_DEPTH = 1,
  parameter bit SYNC_NEG   = 1'b1
)(
  input  logic       vga_pix_clk,
  input  logic       rst_n,
  output logic [7:0] sx,
  output logic [8:0] sy,
  output logic       display_enabled,
  output logic       game_pix_stb,
  output logic       frame_stb,
  input  logic [3:0] R_in,
  input  logic [3:0] G_in,
  input  logic [3:0] B_in,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_OFF   = win_off(H_VISIBLE, GAME_W, SCALE);
  localparam int V_OFF   = win_off(V_VISIBLE, GAME_H, SCALE);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = SCALE > 1 ? $clog2(SCALE) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_WIN0 = HW'(H_OFF);
  localparam logic [HW-1:0] H_WIN1 = HW'(H_OFF + GAME_W * SCALE);
  localparam logic [HW-1:0] H_HS0  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_HS1  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_WIN0 = VW'(V_OFF);
  localparam logic [VW-1:0] V_WIN1 = VW'(V_OFF + GAME_H * SCALE);
  localparam logic [VW-1:0] V_VS0  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_VS1  = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

  if (GAME_W * SCALE > H_VISIBLE || GAME_H * SCALE > V_VISIBLE) begin : g_bad_scale
    $error("pacman_beam_gen: scaled game window exceeds visible area");
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [SW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [7:0]    gx_q, gx_d;
  logic [8:0]    gy_q, gy_d;
  logic [7:0]    sx_q;
  logic [8:0]    sy_q;
  logic          de_q, gstb_q, fstb_q, hs_q, vs_q;
  logic [3:0]    r_q, g_q, b_q;
  logic          h_wrap, in_col, in_row, win, pix0, hs_last, vs_last;
  sync_t         raw, dly;

  // gx/gy and the sub-pixel counters describe the pixel currently held in h/v;
  // they restart whenever the beam is outside the window so each line and
  // frame enters the window at game pixel 0.
  always_comb begin
    h_wrap  = h_q == H_LAST;
    h_d     = h_wrap ? '0 : h_q + 1'b1;
    v_d     = h_wrap ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
    in_col  = h_q >= H_WIN0 && h_q < H_WIN1;
    in_row  = v_q >= V_WIN0 && v_q < V_WIN1;
    win     = in_col && in_row;
    hs_last = hsub_q == S_LAST;
    vs_last = vsub_q == S_LAST;
    hsub_d  = (in_col && !hs_last) ? hsub_q + 1'b1 : '0;
    gx_d    = in_col ? (hs_last ? gx_q + 8'd1 : gx_q) : '0;
    vsub_d  = h_wrap ? ((in_row && !vs_last) ? vsub_q + 1'b1 : '0) : vsub_q;
    gy_d    = h_wrap ? (in_row ? (vs_last ? gy_q + 9'd1 : gy_q) : '0) : gy_q;
    pix0    = win && hsub_q == '0 && vsub_q == '0;
    raw.hs  = h_q >= H_HS0 && h_q < H_HS1;
    raw.vs  = v_q >= V_VS0 && v_q < V_VS1;
    raw.win = win;
  end

  vga_sync_delay #(.N(PIPE_DEPTH + 1)) u_sync_delay (
    .clk_i  (vga_pix_clk),
    .rst_ni (rst_n),
    .d_i    (raw),
    .q_o    (dly)
  );

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      hsub_q <= '0;
      vsub_q <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      de_q   <= 1'b0;
      gstb_q <= 1'b0;
      fstb_q <= 1'b0;
      hs_q   <= SYNC_NEG;
      vs_q   <= SYNC_NEG;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      sx_q   <= win ? gx_q : '0;
      sy_q   <= win ? gy_q : '0;
      de_q   <= win;
      gstb_q <= pix0;
      fstb_q <= pix0 && gx_q == '0 && gy_q == '0;
      hs_q   <= dly.hs ^ SYNC_NEG;
      vs_q   <= dly.vs ^ SYNC_NEG;
      r_q    <= dly.win ? R_in : '0;
      g_q    <= dly.win ? G_in : '0;
      b_q    <= dly.win ? B_in : '0;
    end
  end

  assign sx              = sx_q;
  assign sy              = sy_q;
  assign display_enabled = de_q;
  assign game_pix_stb    = gstb_q;
  assign frame_stb       = fstb_q;
  assign VGA_R           = r_q;
  assign VGA_G           = g_q;
  assign VGA_B           = b_q;
  assign VGA_HS          = hs_q;
  assign VGA_VS          = vs_q;
endmodule

// File: tb/tb_pacman_beam_gen.sv
// tb_pacman_beam_gen: two reduced-timing instances (SCALE=1 active-low sync,
// SCALE=2 active-high sync) checked every cycle against a raster-arithmetic model.
module tb_pacman_beam_gen;
  localparam int HV = 40, HF = 4, HSW = 6, HB = 6;
  localparam int VV = 30, VF = 2, VSW = 2, VB = 3;
  localparam int GW = 10, GH = 8;
  localparam int FR = (HV + HF + HSW + HB) * (VV + VF + VSW + VB);
  localparam int MID = 4949;

  typedef struct {int hv, hf, hsw, hb, vv, vf, vsw, vb, gw, gh, sc, pd, neg;} cfg_t;
  typedef struct {int de, sx, sy, gs, fs, hs, vs, r, g, b;} exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] r_in, g_in, b_in;
  logic [7:0] a_sx, b_sx;
  logic [8:0] a_sy, b_sy;
  logic a_de, a_gs, a_fs, a_hs, a_vs, b_de, b_gs, b_fs, b_hs, b_vs;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  int cyc = 0, n_tot = 0, n_pass = 0;
  bit run = 0, phase0 = 1;
  cfg_t ca, cb;
  int fa1 = -1, fa2 = -1, fb1 = -1, fb2 = -1;
  int gcnt_a = 0, gcnt_b = 0, hcnt_a = 0, hcnt_b = 0, vcnt_a = 0, vcnt_b = 0;

  always #5 clk = ~clk;

  pacman_beam_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .GAME_W(GW), .GAME_H(GH), .SCALE(1), .PIPE_DEPTH(1), .SYNC_NEG(1'b1)
  ) dut_a (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(a_sx), .sy(a_sy),
    .display_enabled(a_de), .game_pix_stb(a_gs), .frame_stb(a_fs),
    .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs)
  );

  pacman_beam_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .GAME_W(GW), .GAME_H(GH), .SCALE(2), .PIPE_DEPTH(2), .SYNC_NEG(1'b0)
  ) dut_b (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(b_sx), .sy(b_sy),
    .display_enabled(b_de), .game_pix_stb(b_gs), .frame_stb(b_fs),
    .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs)
  );

  function automatic int col_r(int c); return (5 * c + 3) & 15; endfunction
  function automatic int col_g(int c); return (3 * c) & 15; endfunction
  function automatic int col_b(int c); return (7 * c + 1) & 15; endfunction

  function automatic bit in_win(cfg_t c, int h, int v);
    int hoff, voff;
    hoff = (c.hv - c.gw * c.sc) / 2;
    voff = (c.vv - c.gh * c.sc) / 2;
    return h >= hoff && h < hoff + c.gw * c.sc && v >= voff && v < voff + c.gh * c.sc;
  endfunction

  // expected outputs in cycle k counted from reset release (k=0: counters at 0)
  function automatic exp_t model(cfg_t c, int k);
    exp_t e;
    int ht, vt, hoff, voff, h, v;
    ht = c.hv + c.hf + c.hsw + c.hb;
    vt = c.vv + c.vf + c.vsw + c.vb;
    hoff = (c.hv - c.gw * c.sc) / 2;
    voff = (c.vv - c.gh * c.sc) / 2;
    e = '{default: 0};
    e.hs = c.neg;
    e.vs = c.neg;
    if (k >= 1) begin
      h = (k - 1) % ht;
      v = ((k - 1) / ht) % vt;
      if (in_win(c, h, v)) begin
        e.de = 1;
        e.sx = (h - hoff) / c.sc;
        e.sy = (v - voff) / c.sc;
        e.gs = int'((h - hoff) % c.sc == 0 && (v - voff) % c.sc == 0);
        e.fs = int'(e.gs == 1 && e.sx == 0 && e.sy == 0);
      end
    end
    if (k >= 2 + c.pd) begin
      h = (k - 2 - c.pd) % ht;
      v = ((k - 2 - c.pd) / ht) % vt;
      e.hs = int'(h >= c.hv + c.hf && h < c.hv + c.hf + c.hsw) ^ c.neg;
      e.vs = int'(v >= c.vv + c.vf && v < c.vv + c.vf + c.vsw) ^ c.neg;
      if (in_win(c, h, v)) begin
        e.r = col_r(k - 1);
        e.g = col_g(k - 1);
        e.b = col_b(k - 1);
      end
    end
    return e;
  endfunction

  task automatic chk(string n, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", n, cyc, act, exp);
  endtask

  task automatic cmp(string t, exp_t a, exp_t e);
    chk({t, ".de"}, a.de, e.de);
    chk({t, ".sx"}, a.sx, e.sx);
    chk({t, ".sy"}, a.sy, e.sy);
    chk({t, ".game_pix_stb"}, a.gs, e.gs);
    chk({t, ".frame_stb"}, a.fs, e.fs);
    chk({t, ".VGA_HS"}, a.hs, e.hs);
    chk({t, ".VGA_VS"}, a.vs, e.vs);
    chk({t, ".VGA_R"}, a.r, e.r);
    chk({t, ".VGA_G"}, a.g, e.g);
    chk({t, ".VGA_B"}, a.b, e.b);
  endtask

  task automatic drive(int c);
    r_in = 4'(col_r(c));
    g_in = 4'(col_g(c));
    b_in = 4'(col_b(c));
  endtask

  always @(negedge clk) begin
    exp_t aa, ab;
    if (run) begin
      aa = '{int'(a_de), int'(a_sx), int'(a_sy), int'(a_gs), int'(a_fs),
             int'(a_hs), int'(a_vs), int'(a_r), int'(a_g), int'(a_b)};
      ab = '{int'(b_de), int'(b_sx), int'(b_sy), int'(b_gs), int'(b_fs),
             int'(b_hs), int'(b_vs), int'(b_r), int'(b_g), int'(b_b)};
      cmp("A", aa, model(ca, rst_n ? cyc : 0));
      cmp("B", ab, model(cb, rst_n ? cyc : 0));
      if (rst_n) begin
        if (a_fs) begin
          if (fa1 < 0) fa1 = cyc;
          else if (fa2 < 0) fa2 = cyc;
        end
        if (b_fs) begin
          if (fb1 < 0) fb1 = cyc;
          else if (fb2 < 0) fb2 = cyc;
        end
        if (phase0 && cyc >= 1 && cyc <= FR) begin
          gcnt_a += int'(a_gs);
          gcnt_b += int'(b_gs);
          vcnt_a += int'(!a_vs);
          vcnt_b += int'(b_vs);
        end
        if (phase0 && cyc >= 1000 && cyc < 1056) begin
          hcnt_a += int'(!a_hs);
          hcnt_b += int'(b_hs);
        end
      end
    end
  end

  initial begin
    ca = '{HV, HF, HSW, HB, VV, VF, VSW, VB, GW, GH, 1, 1, 1};
    cb = '{HV, HF, HSW, HB, VV, VF, VSW, VB, GW, GH, 2, 2, 0};
    rst_n = 1'b0;
    drive(0);
    run = 1;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < MID; i++) begin
      @(posedge clk);
      #1 cyc++;
      drive(cyc);
      if (cyc == 404) begin
        chk("B.sx@404", int'(b_sx), 0);
        chk("B.gs@404", int'(b_gs), 0);
      end
      if (cyc == 405) begin
        chk("B.sx@405", int'(b_sx), 1);
        chk("B.gs@405", int'(b_gs), 1);
      end
      if (cyc == 459) begin
        chk("B.de@459", int'(b_de), 1);
        chk("B.gs@459", int'(b_gs), 0);
        chk("B.sy@459", int'(b_sy), 0);
      end
      if (cyc == 571) chk("B.sy@571", int'(b_sy), 1);
      if (cyc == 633) chk("A.VGA_R@633", int'(a_r), 0);
      if (cyc == 634) chk("A.VGA_G@634", int'(a_g), 11);
      if (cyc == 641) chk("A.sx@641", int'(a_sx), 9);
      if (cyc == 642) chk("A.de@642", int'(a_de), 0);
    end
    chk("A.first_frame_stb", fa1, 632);
    chk("A.second_frame_stb", fa2, 632 + FR);
    chk("B.first_frame_stb", fb1, 403);
    chk("B.second_frame_stb", fb2, 403 + FR);
    chk("A.pix_stb_per_frame", gcnt_a, GW * GH);
    chk("B.pix_stb_per_frame", gcnt_b, GW * GH);
    chk("A.hs_active_per_line", hcnt_a, HSW);
    chk("B.hs_active_per_line", hcnt_b, HSW);
    chk("A.vs_active_per_frame", vcnt_a, 112);
    chk("B.vs_active_per_frame", vcnt_b, 112);
    chk("A.de_before_reset", int'(a_de), 1);
    chk("A.sx_before_reset", int'(a_sx), 5);
    chk("A.VGA_R_before_reset", int'(a_r), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("A.de_async_reset", int'(a_de), 0);
    chk("A.sx_async_reset", int'(a_sx), 0);
    chk("A.VGA_R_async_reset", int'(a_r), 0);
    chk("A.VGA_HS_async_reset", int'(a_hs), 1);
    chk("B.VGA_HS_async_reset", int'(b_hs), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc = 0;
    phase0 = 0;
    drive(0);
    fa1 = -1; fa2 = -1; fb1 = -1; fb2 = -1;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk);
      #1 cyc++;
      drive(cyc);
    end
    chk("A.first_frame_stb_after_mid_reset", fa1, 632);
    chk("B.first_frame_stb_after_mid_reset", fb1, 403);
    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
